// File: rtl/bank_wb_issuer_if.sv
// Writeback-pair bus for bank_wb_issuer: pair input handshake, banked regfile write ports, occupancy.
// master drives the pair input side; slave is the issuer itself.
interface bank_wb_issuer_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             in_valid_i;
    logic             in_ready_o;
    logic             we0_i;
    logic [4:0]       wa0_i;
    logic [WIDTH-1:0] wd0_i;
    logic             we1_i;
    logic [4:0]       wa1_i;
    logic [WIDTH-1:0] wd1_i;
    logic             we0_o;
    logic [4:0]       wa0_o;
    logic [WIDTH-1:0] wd0_o;
    logic             we1_o;
    logic [4:0]       wa1_o;
    logic [WIDTH-1:0] wd1_o;
    logic [CW-1:0]    count_o;
    logic             empty_o;

    modport master (
        output in_valid_i, we0_i, wa0_i, wd0_i, we1_i, wa1_i, wd1_i,
        input  in_ready_o, we0_o, wa0_o, wd0_o, we1_o, wa1_o, wd1_o, count_o, empty_o
    );

    modport slave (
        input  in_valid_i, we0_i, wa0_i, wd0_i, we1_i, wa1_i, wd1_i,
        output in_ready_o, we0_o, wa0_o, wd0_o, we1_o, wa1_o, wd1_o, count_o, empty_o
    );
endinterface

// File: rtl/bank_wb_issuer.sv
// Queues writeback pairs and issues them onto two banked regfile ports (even/odd address).
// Optional same-cycle bypass on an empty queue is enabled by defining BANK_WB_BYPASS_EN.
module bank_wb_issuer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    bank_wb_issuer_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic [DEPTH-1:0] live0_q, live1_q;
    logic [4:0]       wa0_q [DEPTH];
    logic [WIDTH-1:0] wd0_q [DEPTH];
    logic [4:0]       wa1_q [DEPTH];
    logic [WIDTH-1:0] wd1_q [DEPTH];

    logic             in_live0, in_live1, accept;
    logic             head_valid, h_live0, h_live1, head_conflict, pop;
    logic             push, push_live0, push_live1;
    logic             iss0, iss1;
    logic [4:0]       iss0_wa, iss1_wa;
    logic [WIDTH-1:0] iss0_wd, iss1_wd;

    assign in_live0      = bus.we0_i & (|bus.wa0_i);
    assign in_live1      = bus.we1_i & (|bus.wa1_i);
    assign accept        = bus.in_valid_i & bus.in_ready_o;

    assign head_valid    = (count_q != '0);
    assign h_live0       = head_valid & live0_q[rd_ptr_q];
    assign h_live1       = head_valid & live1_q[rd_ptr_q];
    assign head_conflict = h_live0 & h_live1 & (wa0_q[rd_ptr_q][0] == wa1_q[rd_ptr_q][0]);
    assign pop           = head_valid & ~head_conflict;

    // Pick which slots issue this cycle; a same-bank head pair issues slot0 first.
    always_comb begin
        iss0       = h_live0;
        iss0_wa    = wa0_q[rd_ptr_q];
        iss0_wd    = wd0_q[rd_ptr_q];
        iss1       = h_live1 & ~head_conflict;
        iss1_wa    = wa1_q[rd_ptr_q];
        iss1_wd    = wd1_q[rd_ptr_q];
        push       = accept & (in_live0 | in_live1);
        push_live0 = in_live0;
        push_live1 = in_live1;
`ifdef BANK_WB_BYPASS_EN
        if (accept && !head_valid && (in_live0 || in_live1)) begin
            iss0    = in_live0;
            iss0_wa = bus.wa0_i;
            iss0_wd = bus.wd0_i;
            iss1_wa = bus.wa1_i;
            iss1_wd = bus.wd1_i;
            if (in_live0 && in_live1 && (bus.wa0_i[0] == bus.wa1_i[0])) begin
                iss1       = 1'b0;
                push       = 1'b1;
                push_live0 = 1'b0;
            end else begin
                iss1       = in_live1;
                push       = 1'b0;
            end
        end
`endif
    end

    // Route each issuing slot to the port of its bank; idle ports drive zeros.
    always_comb begin
        bus.we0_o = 1'b0;
        bus.wa0_o = '0;
        bus.wd0_o = '0;
        bus.we1_o = 1'b0;
        bus.wa1_o = '0;
        bus.wd1_o = '0;
        if (iss0) begin
            if (iss0_wa[0]) begin
                bus.we1_o = 1'b1;
                bus.wa1_o = iss0_wa;
                bus.wd1_o = iss0_wd;
            end else begin
                bus.we0_o = 1'b1;
                bus.wa0_o = iss0_wa;
                bus.wd0_o = iss0_wd;
            end
        end
        if (iss1) begin
            if (iss1_wa[0]) begin
                bus.we1_o = 1'b1;
                bus.wa1_o = iss1_wa;
                bus.wd1_o = iss1_wd;
            end else begin
                bus.we0_o = 1'b1;
                bus.wa0_o = iss1_wa;
                bus.wd0_o = iss1_wd;
            end
        end
    end

    // A conflicting head keeps its entry and only drops slot0, so slot1 issues next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            live0_q  <= '0;
            live1_q  <= '0;
        end else begin
            if (push) begin
                live0_q[wr_ptr_q] <= push_live0;
                live1_q[wr_ptr_q] <= push_live1;
                wr_ptr_q          <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end else if (head_conflict) begin
                live0_q[rd_ptr_q] <= 1'b0;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            wa0_q[wr_ptr_q] <= bus.wa0_i;
            wd0_q[wr_ptr_q] <= bus.wd0_i;
            wa1_q[wr_ptr_q] <= bus.wa1_i;
            wd1_q[wr_ptr_q] <= bus.wd1_i;
        end
    end

    assign bus.in_ready_o = (count_q < DEPTH_C);
    assign bus.count_o    = count_q;
    assign bus.empty_o    = (count_q == '0);
endmodule

// File: tb/tb_bank_wb_issuer.sv
// Bench for bank_wb_issuer: directed pairs plus random traffic checked each cycle against a
// pair-queue reference model. Follows BANK_WB_BYPASS_EN when it is defined.
module tb_bank_wb_issuer;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    typedef struct {
        bit         l0;
        logic [4:0] a0;
        logic [31:0] d0;
        bit         l1;
        logic [4:0] a1;
        logic [31:0] d1;
    } pair_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    pair_t q[$];
    bit          e_we0, e_we1;
    logic [4:0]  e_wa0, e_wa1;
    logic [31:0] e_wd0, e_wd1;

    bank_wb_issuer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    bank_wb_issuer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic route(input logic [4:0] a, input logic [31:0] d);
        if (a[0]) begin
            e_we1 = 1'b1; e_wa1 = a; e_wd1 = d;
        end else begin
            e_we0 = 1'b1; e_wa0 = a; e_wd0 = d;
        end
    endtask

    // Compute this cycle's expected outputs from the model and current inputs, compare,
    // then optionally advance the model to its state after the coming rising edge.
    task automatic modelStep(input string tag, input bit doUpdate, output bit acc);
        int    sz;
        bit    l0, l1, conf, byp;
        pair_t h, np;
        sz   = q.size();
        acc  = bus.in_valid_i && (sz < DEPTH);
        l0   = bus.we0_i && (bus.wa0_i != 5'd0);
        l1   = bus.we1_i && (bus.wa1_i != 5'd0);
        conf = 1'b0;
        byp  = 1'b0;
        e_we0 = 1'b0; e_wa0 = '0; e_wd0 = '0;
        e_we1 = 1'b0; e_wa1 = '0; e_wd1 = '0;
        np = '{l0, bus.wa0_i, bus.wd0_i, l1, bus.wa1_i, bus.wd1_i};
        if (sz > 0) begin
            h = q[0];
            conf = h.l0 && h.l1 && (h.a0[0] == h.a1[0]);
            if (h.l0) route(h.a0, h.d0);
            if (h.l1 && !conf) route(h.a1, h.d1);
        end
`ifdef BANK_WB_BYPASS_EN
        else if (acc && (l0 || l1)) begin
            byp = 1'b1;
            if (l0) route(bus.wa0_i, bus.wd0_i);
            if (l0 && l1 && (bus.wa0_i[0] == bus.wa1_i[0])) np.l0 = 1'b0;
            else if (l1) route(bus.wa1_i, bus.wd1_i);
        end
`endif
        checkOutput({tag, ":count"}, 64'(bus.count_o), 64'(sz));
        checkOutput({tag, ":empty"}, 64'(bus.empty_o), 64'(sz == 0));
        checkOutput({tag, ":ready"}, 64'(bus.in_ready_o), 64'(sz < DEPTH));
        checkOutput({tag, ":we0"}, 64'(bus.we0_o), 64'(e_we0));
        checkOutput({tag, ":wa0"}, 64'(bus.wa0_o), 64'(e_wa0));
        checkOutput({tag, ":wd0"}, 64'(bus.wd0_o), 64'(e_wd0));
        checkOutput({tag, ":we1"}, 64'(bus.we1_o), 64'(e_we1));
        checkOutput({tag, ":wa1"}, 64'(bus.wa1_o), 64'(e_wa1));
        checkOutput({tag, ":wd1"}, 64'(bus.wd1_o), 64'(e_wd1));
        if (doUpdate) begin
            if (sz > 0) begin
                if (conf) begin
                    h.l0 = 1'b0;
                    q[0] = h;
                end else begin
                    void'(q.pop_front());
                end
            end
            if (acc && (l0 || l1)) begin
                if (!byp) q.push_back(np);
                else if (!np.l0 && l1 && l0) q.push_back(np);
            end
        end
    endtask

    task automatic applyStimulus(input string tag, input bit v,
                                 input bit e0, input logic [4:0] a0, input logic [31:0] d0,
                                 input bit e1, input logic [4:0] a1, input logic [31:0] d1,
                                 output bit acc);
        @(negedge clk);
        bus.in_valid_i = v;
        bus.we0_i = e0; bus.wa0_i = a0; bus.wd0_i = d0;
        bus.we1_i = e1; bus.wa1_i = a1; bus.wd1_i = d1;
        #1;
        modelStep(tag, 1'b1, acc);
    endtask

    task automatic idle(input string tag, input int n);
        bit acc;
        for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
    endtask

    initial begin
        bit acc;
        int tries;
        bus.in_valid_i = 1'b0;
        bus.we0_i = 1'b0; bus.wa0_i = '0; bus.wd0_i = '0;
        bus.we1_i = 1'b0; bus.wa1_i = '0; bus.wd1_i = '0;
        #1;
        modelStep("reset", 1'b0, acc);
        @(negedge clk);
        #2 rst = 1'b0;

        // Independent banks issue together one cycle after acceptance.
        applyStimulus("pair_r4_r7", 1'b1, 1'b1, 5'd4, 32'h11, 1'b1, 5'd7, 32'h22, acc);
        idle("after_r4_r7", 2);

        // Same bank: two consecutive port0 writes.
        applyStimulus("pair_r6_r6", 1'b1, 1'b1, 5'd6, 32'hA, 1'b1, 5'd6, 32'hB, acc);
        idle("after_r6_r6", 3);

        // Dead slots are filtered and nothing is enqueued.
        applyStimulus("dead_pair", 1'b1, 1'b1, 5'd0, 32'h5, 1'b0, 5'd9, 32'h6, acc);
        idle("after_dead", 2);

        // Back-to-back conflicting pairs, held until accepted, fill the queue.
        for (int k = 0; k < 8; k++) begin
            tries = 0;
            do begin
                applyStimulus("conflict_burst", 1'b1, 1'b1, 5'(2 * k + 3), 32'h100 + k,
                              1'b1, 5'(2 * k + 5), 32'h200 + k, acc);
                tries++;
            end while (!acc && tries < 20);
            checkOutput("burst_accept", 64'(acc), 64'd1);
        end
        idle("burst_drain", 20);

        // Reset between the two halves of a split pair drops slot1.
        applyStimulus("split_push", 1'b1, 1'b1, 5'd6, 32'hA, 1'b1, 5'd6, 32'hB, acc);
        applyStimulus("split_slot0", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
        @(negedge clk);
        rst = 1'b1;
        #1;
        q.delete();
        modelStep("mid_split_reset", 1'b0, acc);
        #1 rst = 1'b0;
        idle("after_reset", 3);

        // Random traffic with small addresses so r0 and bank conflicts are frequent.
        for (int i = 0; i < 600; i++) begin
            applyStimulus("random", ($urandom_range(0, 3) != 0),
                          1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                          1'($urandom), 5'($urandom_range(0, 7)), $urandom, acc);
        end
        idle("final_drain", 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
